seq_bin2bcd: RTL and testbench



---
 rtl/seq_bin2bcd.sv | 173 +++++++++++++++++
 tb/tb_seq_bin2bcd.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one adjust/shift step per clock, valid/ready on both sides.
// Optional macro BCD_LZB_EN adds the registered leading-zero blanking output o_blank.
module seq_bin2bcd #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [BIN_W-1:0]      i_bin,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_ovf
`ifdef BCD_LZB_EN
   ,
   output logic [DIGITS-1:0]     o_blank
`endif
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int ACC_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BIN_W-1:0]   r_bin;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_valid;
   logic               r_ready;
   logic [ACC_W-1:0]   r_bcd;
   logic               r_ovf_out;
   logic               w_load;
   logic               w_last;
   logic [ACC_W-1:0]   w_acc_adj;
   logic [ACC_W-1:0]   w_acc_shf;
   logic [BIN_W-1:0]   w_bin_shf;
   logic               w_ovf_nxt;

   // Each digit >= 5 gets +3 independently, so no carry crosses digit boundaries.
   function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0] res;
      res = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5) begin
            res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
         end else begin
            res[4*d +: 4] = acc[4*d +: 4];
         end
      end
      return res;
   endfunction

`ifdef BCD_LZB_EN
   logic [DIGITS-1:0]  r_blank;

   function automatic logic [DIGITS-1:0] lz_blank(input logic [ACC_W-1:0] acc);
      logic [DIGITS-1:0] res;
      logic              zero_above;
      res        = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above && (acc[4*k +: 4] == 4'd0);
         res[k]     = zero_above;
      end
      return res;
   endfunction

   assign o_blank = r_blank;
`endif

   assign w_acc_adj = dabble_adj(r_acc);
   assign w_acc_shf = {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
   assign w_bin_shf = r_bin << 1;
   // A set top bit after adjust is lost by the shift: the value no longer fits.
   assign w_ovf_nxt = r_ovf | w_acc_adj[ACC_W-1];

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_bcd   = r_bcd;
   assign o_ovf   = r_ovf_out;

   // Next-state and load/last-step strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_valid && r_ready) begin
               w_state_nxt = S_SHIFT;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_DONE;
               w_last      = 1'b1;
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Shift datapath, handshake flags and the held result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin     <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_valid   <= 1'b0;
         r_ready   <= 1'b1;
         r_bcd     <= '0;
         r_ovf_out <= 1'b0;
`ifdef BCD_LZB_EN
         r_blank   <= '0;
`endif
      end else begin
         r_valid <= (w_state_nxt == S_DONE);
         r_ready <= (w_state_nxt == S_IDLE);
         if (w_load) begin
            r_bin <= i_bin;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= CNT_W'(BIN_W);
         end else if (r_state == S_SHIFT) begin
            r_bin <= w_bin_shf;
            r_acc <= w_acc_shf;
            r_ovf <= w_ovf_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_last) begin
            r_bcd     <= w_acc_shf;
            r_ovf_out <= w_ovf_nxt;
`ifdef BCD_LZB_EN
            r_blank   <= lz_blank(w_acc_shf);
`endif
         end
      end
   end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench for seq_bin2bcd: default 8-bit/3-digit, 8-bit/2-digit overflow and 16-bit/5-digit instances.
module tb_seq_bin2bcd;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   logic        a_i_valid = 1'b0, a_i_ready = 1'b0;
   logic        a_o_ready, a_o_valid, a_o_ovf;
   logic [7:0]  a_i_bin = 8'd0;
   logic [11:0] a_o_bcd;
   logic        b_i_valid = 1'b0, b_i_ready = 1'b0;
   logic        b_o_ready, b_o_valid, b_o_ovf;
   logic [7:0]  b_i_bin = 8'd0;
   logic [7:0]  b_o_bcd;
   logic        c_i_valid = 1'b0, c_i_ready = 1'b0;
   logic        c_o_ready, c_o_valid, c_o_ovf;
   logic [15:0] c_i_bin = 16'd0;
   logic [19:0] c_o_bcd;
`ifdef BCD_LZB_EN
   logic [2:0]  a_o_blank;
   logic [1:0]  b_o_blank;
   logic [4:0]  c_o_blank;
`endif

   seq_bin2bcd u_dut_a (
      .clk(clk), .rst(rst), .i_valid(a_i_valid), .o_ready(a_o_ready), .i_bin(a_i_bin),
      .o_valid(a_o_valid), .i_ready(a_i_ready), .o_bcd(a_o_bcd), .o_ovf(a_o_ovf)
`ifdef BCD_LZB_EN
      , .o_blank(a_o_blank)
`endif
   );

   seq_bin2bcd #(.BIN_W(8), .DIGITS(2)) u_dut_b (
      .clk(clk), .rst(rst), .i_valid(b_i_valid), .o_ready(b_o_ready), .i_bin(b_i_bin),
      .o_valid(b_o_valid), .i_ready(b_i_ready), .o_bcd(b_o_bcd), .o_ovf(b_o_ovf)
`ifdef BCD_LZB_EN
      , .o_blank(b_o_blank)
`endif
   );

   seq_bin2bcd #(.BIN_W(16), .DIGITS(5)) u_dut_c (
      .clk(clk), .rst(rst), .i_valid(c_i_valid), .o_ready(c_o_ready), .i_bin(c_i_bin),
      .o_valid(c_o_valid), .i_ready(c_i_ready), .o_bcd(c_o_bcd), .o_ovf(c_o_ovf)
`ifdef BCD_LZB_EN
      , .o_blank(c_o_blank)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] bcd5_model(input int unsigned v);
      logic [19:0] r;
      r = 20'd0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Default instance: accept, noisy inputs during SHIFT/DONE, hold under back-pressure, handshake.
   task automatic run_a(input logic [7:0] v, input int hold, input logic [11:0] exp_bcd,
                        input logic [2:0] exp_blank);
      int lat;
      @(negedge clk);
      check_val("a_ready_idle", 32'(a_o_ready), 32'd1);
      a_i_valid = 1'b1;
      a_i_bin   = v;
      @(posedge clk);
      @(negedge clk);
      a_i_valid = 1'b0;
      a_i_bin   = ~v;
      check_val("a_ready_shift", 32'(a_o_ready), 32'd0);
      lat = 0;
      while (!a_o_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         a_i_valid = 1'($urandom_range(0, 1));
         a_i_bin   = 8'($urandom);
      end
      a_i_valid = 1'b0;
      check_val("a_latency", 32'(lat), 32'd8);
      check_val("a_bcd", 32'(a_o_bcd), 32'(exp_bcd));
      check_val("a_ovf", 32'(a_o_ovf), 32'd0);
`ifdef BCD_LZB_EN
      check_val("a_blank", 32'(a_o_blank), 32'(exp_blank));
`else
      if (exp_blank === 3'bxxx) $display("unused blank expectation");
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("a_hold_valid", 32'(a_o_valid), 32'd1);
         check_val("a_hold_bcd", 32'(a_o_bcd), 32'(exp_bcd));
         check_val("a_hold_ready", 32'(a_o_ready), 32'd0);
         a_i_valid = 1'($urandom_range(0, 1));
         a_i_bin   = 8'($urandom);
      end
      a_i_valid = 1'b0;
      a_i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_i_ready = 1'b0;
      check_val("a_post_valid", 32'(a_o_valid), 32'd0);
      check_val("a_post_ready", 32'(a_o_ready), 32'd1);
      check_val("a_post_bcd_kept", 32'(a_o_bcd), 32'(exp_bcd));
   endtask

   task automatic run_b(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf);
      int lat;
      @(negedge clk);
      b_i_valid = 1'b1;
      b_i_bin   = v;
      @(posedge clk);
      @(negedge clk);
      b_i_valid = 1'b0;
      lat = 0;
      while (!b_o_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_val("b_latency", 32'(lat), 32'd8);
      check_val("b_bcd", 32'(b_o_bcd), 32'(exp_bcd));
      check_val("b_ovf", 32'(b_o_ovf), 32'(exp_ovf));
      b_i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_i_ready = 1'b0;
      check_val("b_post_valid", 32'(b_o_valid), 32'd0);
   endtask

   task automatic run_c(input logic [15:0] v, input int hold);
      int lat;
      logic [19:0] exp_bcd;
      exp_bcd = bcd5_model(32'(v));
      @(negedge clk);
      check_val("c_ready_idle", 32'(c_o_ready), 32'd1);
      c_i_valid = 1'b1;
      c_i_bin   = v;
      @(posedge clk);
      @(negedge clk);
      c_i_valid = 1'b0;
      c_i_bin   = 16'($urandom);
      lat = 0;
      while (!c_o_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check_val("c_latency", 32'(lat), 32'd16);
      check_val("c_bcd", 32'(c_o_bcd), 32'(exp_bcd));
      check_val("c_ovf", 32'(c_o_ovf), 32'd0);
      repeat (hold) @(negedge clk);
      check_val("c_hold_bcd", 32'(c_o_bcd), 32'(exp_bcd));
      c_i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      c_i_ready = 1'b0;
      check_val("c_post_valid", 32'(c_o_valid), 32'd0);
   endtask

   initial begin
      int seen;
      #2 rst = 1'b1;
      #2;
      check_val("rst_ready", 32'(a_o_ready), 32'd1);
      check_val("rst_valid", 32'(a_o_valid), 32'd0);
      check_val("rst_bcd", 32'(a_o_bcd), 32'd0);
      check_val("rst_ovf", 32'(a_o_ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_a(8'd255, 0, 12'h255, 3'b000);
      run_a(8'd0,   0, 12'h000, 3'b110);
      run_a(8'd100, 1, 12'h100, 3'b000);
      run_a(8'd7,   0, 12'h007, 3'b110);
      run_a(8'd42,  5, 12'h042, 3'b100);

      // Reset in the middle of a conversion of 199.
      @(negedge clk);
      a_i_valid = 1'b1;
      a_i_bin   = 8'd199;
      @(posedge clk);
      @(negedge clk);
      a_i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("midrst_valid", 32'(a_o_valid), 32'd0);
      check_val("midrst_bcd", 32'(a_o_bcd), 32'd0);
      check_val("midrst_ready", 32'(a_o_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (a_o_valid) seen = 1;
      end
      check_val("midrst_no_pulse", 32'(seen), 32'd0);
      run_a(8'd57, 0, 12'h057, 3'b100);

      run_b(8'd255, 8'h55, 1'b1);
      run_b(8'd99,  8'h99, 1'b0);

      run_c(16'd65535, 0);
      check_val("c_65535_direct", 32'(c_o_bcd), 32'h65535);
      for (int n = 0; n < 200; n++) begin
         run_c(16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
